// File: rtl/ca_pkg.sv
// Shared constants for the cellular-automaton rule engine: preset rules,
// preset select codes, FSM state codes and chunk-count helper.
package ca_pkg;

    localparam logic [7:0] RULE_30  = 8'd30;
    localparam logic [7:0] RULE_54  = 8'd54;
    localparam logic [7:0] RULE_60  = 8'd60;
    localparam logic [7:0] RULE_182 = 8'd182;

    localparam logic [1:0] PSEL_30  = 2'b00;
    localparam logic [1:0] PSEL_54  = 2'b01;
    localparam logic [1:0] PSEL_60  = 2'b10;
    localparam logic [1:0] PSEL_182 = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    // Number of LOAD_W-wide chunks needed to carry a RULE_W-bit rule.
    function automatic int unsigned ca_nchunk(input int unsigned rule_w,
                                              input int unsigned load_w);
        return (rule_w + load_w - 1) / load_w;
    endfunction

    // Preset rule selected by preset_sel.
    function automatic logic [7:0] ca_preset(input logic [1:0] sel);
        logic [7:0] r;
        case (sel)
            PSEL_30:  r = RULE_30;
            PSEL_54:  r = RULE_54;
            PSEL_60:  r = RULE_60;
            default:  r = RULE_182;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ca_rule_lookup.sv
// One cell's next-state lookup: the neighbourhood pattern indexes the rule.
module ca_rule_lookup #(
    parameter int unsigned NBHD   = 3,
    parameter int unsigned RULE_W = 8
) (
    input  logic [RULE_W-1:0] rule,
    input  logic [NBHD-1:0]   nbhd,
    output logic              cell_next_c
);

    // Pure index into the rule word.
    assign cell_next_c = rule[nbhd];

endmodule

// File: rtl/ca_rule_engine.sv
// Rule store (active + shadow) with preset / streamed loading, commit on
// generation boundary, and NCELLS parallel lookups.
// Optional macro CA_RULE_ENGINE_REG_OUT_EN registers next_state (1-cycle latency).
module ca_rule_engine
    import ca_pkg::*;
#(
    parameter int unsigned RADIUS = 1,
    parameter int unsigned NCELLS = 8,
    parameter int unsigned LOAD_W = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [1:0]                          preset_sel,
    input  logic                                preset_load,
    input  logic                                load_valid,
    output logic                                load_ready,
    input  logic [LOAD_W-1:0]                   load_data,
    input  logic                                load_last,
    input  logic                                gen_tick,
    input  logic [NCELLS*(2*RADIUS+1)-1:0]      nbhd,
    output logic [NCELLS-1:0]                   next_state,
    output logic [(1 << (2*RADIUS+1))-1:0]      active_rule,
    output logic                                pending,
    output logic                                load_err
);

    localparam int unsigned NBHD   = 2 * RADIUS + 1;
    localparam int unsigned RULE_W = 1 << NBHD;
    localparam int unsigned NCHUNK = ca_nchunk(RULE_W, LOAD_W);
    localparam int unsigned CNT_W  = $clog2(NCHUNK) + 1;
    localparam int unsigned EXT_W  = NCHUNK * LOAD_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_n;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RULE_W-1:0] shadow_q, shadow_d;
    logic [RULE_W-1:0] active_q, active_d;
    logic              err_q, err_d;
    logic              pend_q, pend_d;
    logic              ready_q, ready_d;
    logic              accept;
    logic [CNT_W-1:0]  wr_idx;
    logic [EXT_W-1:0]  shadow_ext;
    logic [NCELLS-1:0] lookup_c;

    // Reset synchroniser: asserts immediately, releases on the clock.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    // Next-state logic: chunk framing, preset staging and commit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = err_q;
        accept   = load_valid && ready_q;
        wr_idx   = (state_q == ST_LOAD) ? cnt_q : '0;

        // Shadow with the incoming chunk merged in; bits above RULE_W fall off.
        shadow_ext = EXT_W'(shadow_q);
        for (int unsigned c = 0; c < NCHUNK; c++) begin
            if (CNT_W'(c) == wr_idx) shadow_ext[c*LOAD_W +: LOAD_W] = load_data;
        end

        if (accept && (state_q != ST_PEND)) begin
            shadow_d = shadow_ext[RULE_W-1:0];
            if (wr_idx == LAST_IDX) begin
                cnt_d = '0;
                if (load_last) begin
                    state_d = ST_PEND;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end else if (load_last) begin
                err_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end else begin
                cnt_d   = wr_idx + CNT_W'(1);
                state_d = ST_LOAD;
            end
        end else if ((state_q == ST_IDLE) && preset_load) begin
            shadow_d = RULE_W'(ca_preset(preset_sel));
            state_d  = ST_PEND;
        end else if ((state_q == ST_PEND) && gen_tick) begin
            active_d = shadow_q;
            err_d    = 1'b0;
            state_d  = ST_IDLE;
        end

        pend_d  = (state_d == ST_PEND);
        ready_d = (state_d != ST_PEND);
    end

    // State and rule registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= RULE_W'(RULE_30);
            active_q <= RULE_W'(RULE_30);
            err_q    <= 1'b0;
            pend_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
        end
    end

    assign load_ready  = ready_q;
    assign pending     = pend_q;
    assign load_err    = err_q;
    assign active_rule = active_q;

    // Parallel per-cell lookup against the active rule.
    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        ca_rule_lookup #(
            .NBHD   (NBHD),
            .RULE_W (RULE_W)
        ) u_lookup (
            .rule        (active_q),
            .nbhd        (nbhd[i*NBHD +: NBHD]),
            .cell_next_c (lookup_c[i])
        );
    end

`ifdef CA_RULE_ENGINE_REG_OUT_EN
    logic [NCELLS-1:0] next_state_q, next_state_d;

    always_comb next_state_d = lookup_c;

    // Registered lookup result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) next_state_q <= '0;
        else        next_state_q <= next_state_d;
    end

    assign next_state = next_state_q;
`else
    assign next_state = lookup_c;
`endif

endmodule
